// File: rtl/frame_gen_pkg.sv
// rtl/frame_gen_pkg.sv - shared state encoding and sizing helpers for frame_gen
package frame_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEAD    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } fg_state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int beat_count(input int bits, input int width);
    return bits / width;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prbs_par_gen.sv
// rtl/prbs_par_gen.sv - Fibonacci PRBS source producing NBITS steps per enable
module prbs_par_gen #(
  parameter int POLY_LENGTH = 7,
  parameter int POLY_TAP    = 6,
  parameter int NBITS       = 8,
  parameter bit INV         = 1'b0
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  output logic [NBITS-1:0] data
);

  logic [POLY_LENGTH-1:0] s;
  logic [POLY_LENGTH-1:0] s_nxt;

  // Unrolled NBITS steps; the earliest step lands in the MSB of data.
  always_comb begin
    s_nxt = s;
    data  = '0;
    for (int i = 0; i < NBITS; i++) begin
      data[NBITS-1-i] = s_nxt[POLY_LENGTH-1] ^ s_nxt[POLY_TAP-1] ^ INV;
      s_nxt = {s_nxt[POLY_LENGTH-2:0], s_nxt[POLY_LENGTH-1] ^ s_nxt[POLY_TAP-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      s <= '1;
    end else if (en) begin
      s <= s_nxt;
    end
  end

endmodule

// File: rtl/frame_gen.sv
// rtl/frame_gen.sv - framed header + PRBS payload generator with valid/ready output
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                HEAD_LEN     = 16,
  parameter logic [HEAD_LEN-1:0] HEAD_PATTERN = 16'hA5C3,
  parameter int                PAYLOAD_BITS = 64,
  parameter int                GAP_BEATS    = 2,
  parameter int                POLY_LENGTH  = 7,
  parameter int                POLY_TAP     = 6,
  parameter bit                INV_PATTERN  = 1'b0,
  parameter bit                RESEED       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_frames,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int HEAD_BEATS = beat_count(HEAD_LEN, DATA_W);
  localparam int PAY_BEATS  = beat_count(PAYLOAD_BITS, DATA_W);
  localparam int CNT_W      = clog2_f(max_i(HEAD_LEN, PAYLOAD_BITS) / DATA_W) + 1;
  localparam int GAP_W      = clog2_f(GAP_BEATS + 1) + 1;

  localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(HEAD_BEATS - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_BEATS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);

  fg_state_e          state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [15:0]        num_q, num_nxt;
  logic [15:0]        frame_nxt;
  logic               done_nxt;
  logic               prbs_load, prbs_en;
  logic [DATA_W-1:0]  prbs_data;
  logic [HEAD_LEN-1:0] head_sh;

  prbs_par_gen #(
    .POLY_LENGTH (POLY_LENGTH),
    .POLY_TAP    (POLY_TAP),
    .NBITS       (DATA_W),
    .INV         (INV_PATTERN)
  ) u_prbs (
    .clk  (clk),
    .load (rst | prbs_load),
    .en   (prbs_en),
    .data (prbs_data)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      num_q     <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      gap_cnt   <= gap_nxt;
      num_q     <= num_nxt;
      frame_cnt <= frame_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    gap_nxt   = gap_cnt;
    num_nxt   = num_q;
    frame_nxt = frame_cnt;
    done_nxt  = 1'b0;
    prbs_load = 1'b0;
    prbs_en   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    head_sh   = HEAD_PATTERN << (DATA_W * int'(beat_cnt));

    case (state)
      S_IDLE: begin
        if (start) begin
          num_nxt   = num_frames;
          frame_nxt = '0;
          beat_nxt  = '0;
          prbs_load = 1'b1;
          state_nxt = S_HEAD;
        end
      end

      S_HEAD: begin
        out_valid = 1'b1;
        out_data  = head_sh[HEAD_LEN-1 -: DATA_W];
        out_sof   = (beat_cnt == '0);
        if (out_ready) begin
          if (beat_cnt == HEAD_LAST) begin
            beat_nxt  = '0;
            state_nxt = S_PAYLOAD;
          end else begin
            beat_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end

      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = prbs_data;
        out_eof   = (beat_cnt == PAY_LAST);
        if (out_ready) begin
          prbs_en = 1'b1;
          if (beat_cnt == PAY_LAST) begin
            beat_nxt  = '0;
            frame_nxt = frame_cnt + 16'd1;
            if ((num_q != 16'd0) && (frame_cnt + 16'd1 == num_q)) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else if (GAP_BEATS == 0) begin
              state_nxt = S_HEAD;
              prbs_load = RESEED;
            end else begin
              gap_nxt   = '0;
              state_nxt = S_GAP;
            end
          end else begin
            beat_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          beat_nxt  = '0;
          prbs_load = RESEED;
          state_nxt = S_HEAD;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides any start, transfer or frame completion this cycle.
    if (abort) begin
      state_nxt = S_IDLE;
      beat_nxt  = '0;
      gap_nxt   = '0;
      num_nxt   = num_q;
      frame_nxt = frame_cnt;
      done_nxt  = 1'b0;
      prbs_load = 1'b0;
      prbs_en   = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_gen.sv
// tb/tb_frame_gen.sv - directed self-checking bench for frame_gen
module tb_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start_aux, abort, out_ready;
  logic [15:0] num_frames;

  logic        out_valid, out_sof, out_eof, busy, done;
  logic [7:0]  out_data;
  logic [15:0] frame_cnt;

  logic        i_valid, i_sof, i_eof, i_busy, i_done;
  logic [7:0]  i_data;
  logic [15:0] i_fc;

  logic        w_valid, w_sof, w_eof, w_busy, w_done;
  logic [0:0]  w_data;
  logic [15:0] w_fc;

  logic        n_valid, n_sof, n_eof, n_busy, n_done;
  logic [7:0]  n_data;
  logic [15:0] n_fc;

  frame_gen dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  frame_gen #(.INV_PATTERN(1'b1)) u_inv (
    .clk(clk), .rst(rst), .start(start_aux), .num_frames(num_frames), .abort(abort),
    .out_ready(out_ready), .out_valid(i_valid), .out_data(i_data),
    .out_sof(i_sof), .out_eof(i_eof), .busy(i_busy), .done(i_done), .frame_cnt(i_fc)
  );

  frame_gen #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_aux), .num_frames(num_frames), .abort(abort),
    .out_ready(out_ready), .out_valid(w_valid), .out_data(w_data),
    .out_sof(w_sof), .out_eof(w_eof), .busy(w_busy), .done(w_done), .frame_cnt(w_fc)
  );

  frame_gen #(.RESEED(1'b0)) u_nrs (
    .clk(clk), .rst(rst), .start(start_aux), .num_frames(num_frames), .abort(abort),
    .out_ready(out_ready), .out_valid(n_valid), .out_data(n_data),
    .out_sof(n_sof), .out_eof(n_eof), .busy(n_busy), .done(n_done), .frame_cnt(n_fc)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit         t_v[256], t_s[256], t_e[256], t_r[256], t_dn[256], t_bz[256];
  logic [7:0] t_d[256], t_id[256], t_nd[256];
  bit         t_wv[256], t_ws[256], t_nv[256];
  logic       t_wd[256];

  logic [7:0] acc_d[$];
  bit         acc_s[$], acc_e[$];
  logic [7:0] nacc[$];
  logic [7:0] exp_d[10];
  logic [6:0] ref_s;
  logic [7:0] rb;
  logic [15:0] w_bits;
  logic [7:0]  w_pay;
  int bad, cnt, idx, runs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference PRBS x^7+x^6+1, all-ones seed, earliest bit first in MSB.
  task automatic ref_next(output logic [7:0] b);
    logic fb;
    for (int k = 7; k >= 0; k--) begin
      fb    = ref_s[6] ^ ref_s[5];
      b[k]  = fb;
      ref_s = {ref_s[5:0], fb};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] n, input bit aux);
    num_frames = n;
    start      = 1'b1;
    start_aux  = aux;
    step();
    start      = 1'b0;
    start_aux  = 1'b0;
  endtask

  task automatic trace(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      #1;
      t_v[i] = out_valid; t_d[i] = out_data; t_s[i] = out_sof; t_e[i] = out_eof;
      t_r[i] = out_ready; t_dn[i] = done; t_bz[i] = busy;
      t_id[i] = i_data; t_wv[i] = w_valid; t_wd[i] = w_data[0]; t_ws[i] = w_sof;
      t_nv[i] = n_valid; t_nd[i] = n_data;
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic collect(input int n);
    acc_d.delete(); acc_s.delete(); acc_e.delete(); nacc.delete();
    for (int i = 0; i < n; i++) begin
      if (t_v[i] && t_r[i]) begin
        acc_d.push_back(t_d[i]); acc_s.push_back(t_s[i]); acc_e.push_back(t_e[i]);
      end
      if (t_nv[i] && t_r[i]) nacc.push_back(t_nd[i]);
    end
  endtask

  task automatic compare_frame(input string tag);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      if (j >= acc_d.size()) bad++;
      else if (acc_d[j] !== exp_d[j] || acc_s[j] !== (j == 0) || acc_e[j] !== (j == 9)) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic done_stats(input int n);
    cnt = 0; idx = -1;
    for (int i = 0; i < n; i++) begin
      if (t_dn[i]) begin
        cnt++;
        if (idx < 0) idx = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_aux = 1'b0; abort = 1'b0;
    out_ready = 1'b1; num_frames = 16'd0;
    exp_d[0] = 8'hA5; exp_d[1] = 8'hC3;
    ref_s = 7'h7F;
    for (int j = 2; j < 10; j++) begin
      ref_next(rb);
      exp_d[j] = rb;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eof", out_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Single frame, ready always high; aux instances run alongside.
    pulse_start(16'd1, 1'b1);
    trace(24, 1'b0);
    collect(24);
    check("s1_valid_first_cycle", t_v[0], 1);
    check("s1_beat_count", acc_d.size(), 10);
    check("s1_head0", acc_d[0], 8'hA5);
    check("s1_head1", acc_d[1], 8'hC3);
    check("s1_pay0", acc_d[2], 8'h02);
    check("s1_pay1", acc_d[3], 8'h0C);
    compare_frame("s1_stream");
    done_stats(24);
    check("s1_done_index", idx, 10);
    check("s1_done_count", cnt, 1);
    check("s1_frame_cnt", frame_cnt, 1);
    check("s1_busy_end", busy, 0);
    check("s2_inv_pay0", t_id[2], 8'hFD);
    w_bits = '0;
    for (int i = 0; i < 16; i++) w_bits[15-i] = t_wd[i];
    w_pay = '0;
    for (int i = 0; i < 8; i++) w_pay[7-i] = t_wd[16+i];
    check("s2_w1_sof", t_ws[0] && t_wv[0], 1);
    check("s2_w1_header", w_bits, 16'hA5C3);
    check("s2_w1_payload", w_pay, 8'h02);

    // Pseudo-random backpressure.
    pulse_start(16'd1, 1'b0);
    trace(100, 1'b1);
    collect(100);
    check("s3_beat_count", acc_d.size(), 10);
    compare_frame("s3_stream");
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      if (t_v[i] && !t_r[i] &&
          (!t_v[i+1] || t_d[i+1] !== t_d[i] || t_s[i+1] !== t_s[i] || t_e[i+1] !== t_e[i]))
        bad++;
    end
    check("s3_stall_hold", bad, 0);
    done_stats(100);
    check("s3_done_count", cnt, 1);

    // Three frames: reseeding main instance and continuous-PRBS instance.
    pulse_start(16'd3, 1'b1);
    trace(40, 1'b0);
    collect(40);
    check("s4_beat_count", acc_d.size(), 30);
    check("s4_f1_pay0", acc_d[2], 8'h02);
    check("s4_f2_pay0", acc_d[12], 8'h02);
    check("s4_f3_pay0", acc_d[22], 8'h02);
    check("s4_f2_sof_head", {acc_s[10], acc_d[10]}, {1'b1, 8'hA5});
    cnt = 0; runs = 0;
    for (int i = 0; i < 40; i++) begin
      if (t_bz[i] && !t_v[i]) begin
        cnt++;
        if (i == 0 || !(t_bz[i-1] && !t_v[i-1])) runs++;
      end
    end
    check("s4_gap_cycles", cnt, 4);
    check("s4_gap_runs", runs, 2);
    done_stats(40);
    check("s4_done_count", cnt, 1);
    check("s4_frame_cnt", frame_cnt, 3);
    ref_s = 7'h7F;
    for (int j = 0; j < 9; j++) ref_next(rb);
    check("s4_nrs_beat_count", nacc.size(), 30);
    check("s4_nrs_f1_pay0", nacc[2], 8'h02);
    check("s4_nrs_f2_pay0", nacc[12], rb);

    // Continuous run aborted in the second payload, with a competing start.
    pulse_start(16'd0, 1'b0);
    repeat (14) step();
    #1;
    check("s5_in_payload", {out_valid, out_data}, {1'b1, 8'h02});
    check("s5_frame_cnt_pre", frame_cnt, 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    #1;
    check("s5_valid_after_abort", out_valid, 0);
    check("s5_busy_after_abort", busy, 0);
    check("s5_done_after_abort", done, 0);
    check("s5_frame_cnt_hold", frame_cnt, 1);
    step();
    check("s5_start_ignored", busy, 0);
    check("s5_no_done", done, 0);

    // Reset in the middle of the header, then a clean run.
    pulse_start(16'd1, 1'b0);
    #1;
    check("s6_mid_head", out_data, 8'hA5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("s6_rst_outputs", {out_valid, out_data, out_sof, out_eof, busy, done}, 0);
    check("s6_rst_frame_cnt", frame_cnt, 0);
    pulse_start(16'd1, 1'b0);
    #1;
    check("s6_restart_head0", {out_valid, out_sof, out_data}, {2'b11, 8'hA5});
    step();
    #1;
    check("s6_restart_head1", {out_valid, out_sof, out_data}, {2'b10, 8'hC3});
    step();
    #1;
    check("s6_restart_pay0", out_data, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
